// File: rtl/motor_plant.sv
// motor_plant: plant model of a motorised shutter.
// Integrates travel position from the controller's motor_up/motor_dn drives and
// decodes the up_limit/dn_limit switches the controller expects to see.
// Position advances one step every STEP_DIV clocks of valid drive, saturating at
// 0 and TRAVEL. Driving up and down in the same cycle latches a sticky fault that
// freezes the plant until reset.
// Optional feature: define MOTOR_PLANT_INERTIA_EN to add a spin-up delay of SPINUP
// cycles before stepping starts after each new drive request.
module motor_plant #(
   parameter int unsigned POS_W    = 16,
   parameter int unsigned TRAVEL   = 1000,
   parameter int unsigned STEP_DIV = 4,
   parameter int unsigned INIT_POS = 0,
   parameter int unsigned SPINUP   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             motor_up,
   input  logic             motor_dn,
   output logic             up_limit,
   output logic             dn_limit,
   output logic [POS_W-1:0] position,
   output logic             moving,
   output logic             fault
);

   // A 1-bit prescaler still exists when STEP_DIV is 1; it just never leaves 0.
   localparam int unsigned      PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);
   localparam logic [POS_W-1:0] POS_TOP  = POS_W'(TRAVEL);
   localparam logic [POS_W-1:0] POS_INIT = POS_W'(INIT_POS);

   logic [POS_W-1:0] pos_q,     pos_d;
   logic [PRE_W-1:0] pre_q,     pre_d;
   logic             moving_q,  moving_d;
   logic             fault_q,   fault_d;
   logic             last_up_q, last_up_d;
   logic             last_dn_q, last_dn_d;

   logic             drv_up;
   logic             drv_dn;
   logic             dir_chg;
   logic             can_up;
   logic             can_dn;
   logic             spun;
   logic             step_up;
   logic             step_dn;
   logic [PRE_W-1:0] pre_base;

   // Qualify the raw drives: conflicting requests or a latched fault inhibit motion.
   always_comb begin
      drv_up  = motor_up & ~motor_dn & ~fault_q;
      drv_dn  = motor_dn & ~motor_up & ~fault_q;
      // Reversal without an idle cycle in between must also discard a partial step.
      dir_chg = (drv_up & last_dn_q) | (drv_dn & last_up_q);
      can_up  = drv_up & (pos_q < POS_TOP);
      can_dn  = drv_dn & (pos_q != '0);
   end

`ifdef MOTOR_PLANT_INERTIA_EN
   localparam int unsigned      SPIN_W    = $clog2(SPINUP + 1);
   localparam logic [SPIN_W-1:0] SPIN_DONE = SPIN_W'(SPINUP);

   logic [SPIN_W-1:0] spin_q, spin_d;
   logic [SPIN_W-1:0] spin_base;

   // Spin-up: count consecutive cycles of drive in one direction, saturating at SPINUP.
   // A reversal restarts the count, so the reversing cycle is the first of the new spin-up.
   always_comb begin
      spin_base = dir_chg ? '0 : spin_q;
      spun      = (spin_base == SPIN_DONE);
      if (drv_up | drv_dn) begin
         if (spun) begin
            spin_d = spin_base;
         end else begin
            spin_d = spin_base + SPIN_W'(1);
         end
      end else begin
         spin_d = '0;
      end
   end

   // Spin-up counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spin_q <= '0;
      end else begin
         spin_q <= spin_d;
      end
   end
`else
   // Without inertia the motor is always up to speed.
   always_comb begin
      spun = 1'b1;
   end
`endif

   // Prescaler and position integration; at a limit the drive toward it is ignored.
   always_comb begin
      pos_d     = pos_q;
      pre_d     = '0;
      moving_d  = 1'b0;
      pre_base  = dir_chg ? '0 : pre_q;
      step_up   = can_up & spun;
      step_dn   = can_dn & spun;
      last_up_d = drv_up;
      last_dn_d = drv_dn;
      fault_d   = fault_q | (motor_up & motor_dn);
      if (step_up | step_dn) begin
         moving_d = 1'b1;
         if (pre_base == PRE_LAST) begin
            pre_d = '0;
            if (step_up) begin
               pos_d = pos_q + POS_W'(1);
            end else begin
               pos_d = pos_q - POS_W'(1);
            end
         end else begin
            pre_d = pre_base + PRE_W'(1);
            pos_d = pos_q;
         end
      end else begin
         // No valid drive, limit reached or still spinning up: partial step is dropped.
         pre_d    = '0;
         moving_d = 1'b0;
         pos_d    = pos_q;
      end
   end

   // State registers; reset reloads INIT_POS immediately, even mid-travel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_q     <= POS_INIT;
         pre_q     <= '0;
         moving_q  <= 1'b0;
         fault_q   <= 1'b0;
         last_up_q <= 1'b0;
         last_dn_q <= 1'b0;
      end else begin
         pos_q     <= pos_d;
         pre_q     <= pre_d;
         moving_q  <= moving_d;
         fault_q   <= fault_d;
         last_up_q <= last_up_d;
         last_dn_q <= last_dn_d;
      end
   end

   assign position = pos_q;
   assign up_limit = (pos_q == POS_TOP);
   assign dn_limit = (pos_q == '0);
   assign moving   = moving_q;
   assign fault    = fault_q;

endmodule

// File: tb/tb_motor_plant.sv
// Bench for motor_plant (default build). Stimulus is issued on the falling edge and
// the expected plant state after the next rising edge is queued; a monitor pops and
// compares it just after that rising edge. The reference model counts consecutive
// cycles of unobstructed drive and steps on every STEP_DIV-th one.
module tb_motor_plant;
   localparam int unsigned POS_W    = 16;
   localparam int unsigned TRAVEL   = 1000;
   localparam int unsigned STEP_DIV = 4;
   localparam int unsigned INIT_POS = 0;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             motor_up = 1'b0;
   logic             motor_dn = 1'b0;
   logic             up_limit;
   logic             dn_limit;
   logic [POS_W-1:0] position;
   logic             moving;
   logic             fault;

   motor_plant #(
      .POS_W(POS_W), .TRAVEL(TRAVEL), .STEP_DIV(STEP_DIV), .INIT_POS(INIT_POS), .SPINUP(8)
   ) dut (
      .clk(clk), .rst(rst), .motor_up(motor_up), .motor_dn(motor_dn),
      .up_limit(up_limit), .dn_limit(dn_limit), .position(position),
      .moving(moving), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      int pos;
      bit upl;
      bit dnl;
      bit mv;
      bit flt;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks  = 0;
   int   errors  = 0;
   int   printed = 0;
   int   cyc_no  = 0;

   // reference model state
   int   m_pos;
   bit   m_fault;
   int   m_dir;   // 0 none, 1 up, 2 down
   int   m_run;   // consecutive unobstructed cycles in m_dir

   function automatic void model_reset();
      m_pos   = INIT_POS;
      m_fault = 1'b0;
      m_dir   = 0;
      m_run   = 0;
   endfunction

   function automatic void model_step(bit u, bit d);
      exp_t e;
      int   dir;
      bit   blocked;
      bit   mv;
      dir     = (u && !d && !m_fault) ? 1 : ((d && !u && !m_fault) ? 2 : 0);
      blocked = (dir == 1 && m_pos == TRAVEL) || (dir == 2 && m_pos == 0);
      mv      = 1'b0;
      if (dir != 0 && !blocked) begin
         m_run = (dir == m_dir) ? m_run + 1 : 1;
         m_dir = dir;
         mv    = 1'b1;
         if (m_run % STEP_DIV == 0) m_pos = (dir == 1) ? m_pos + 1 : m_pos - 1;
      end else begin
         m_run = 0;
         m_dir = 0;
      end
      if (u && d) m_fault = 1'b1;
      e.pos = m_pos;
      e.upl = (m_pos == TRAVEL);
      e.dnl = (m_pos == 0);
      e.mv  = mv;
      e.flt = m_fault;
      sb.push_back(e);
   endfunction

   task automatic check_val(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic cyc(bit u, bit d);
      @(negedge clk);
      motor_up = u;
      motor_dn = d;
      cyc_no++;
      model_step(u, d);
   endtask

   task automatic hold(bit u, bit d, int n);
      repeat (n) cyc(u, d);
   endtask

   // wait until the rising edge targeted by the last cyc() has been applied
   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(string tag);
      @(negedge clk);
      rst      = 1'b1;
      motor_up = 1'b0;
      motor_dn = 1'b0;
      model_reset();
      #1;
      check_val({tag, "_pos"},      int'(position), INIT_POS);
      check_val({tag, "_dn_limit"}, int'(dn_limit), (INIT_POS == 0) ? 1 : 0);
      check_val({tag, "_up_limit"}, int'(up_limit), (INIT_POS == TRAVEL) ? 1 : 0);
      check_val({tag, "_fault"},    int'(fault),    0);
      check_val({tag, "_moving"},   int'(moving),   0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // scoreboard monitor: compare the queued expectation just after each rising edge
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         checks++;
         if ({position, up_limit, dn_limit, moving, fault} !==
             {POS_W'(mon_e.pos), mon_e.upl, mon_e.dnl, mon_e.mv, mon_e.flt}) begin
            errors++;
            if (printed < 20) begin
               $display("FAIL sb_state t=%0t pos/upl/dnl/mv/flt got %0d/%b/%b/%b/%b expected %0d/%b/%b/%b/%b",
                        $time, position, up_limit, dn_limit, moving, fault,
                        mon_e.pos, mon_e.upl, mon_e.dnl, mon_e.mv, mon_e.flt);
            end
            printed++;
         end
      end
   end

   initial begin
      int mode;
      int len;
      model_reset();
      do_reset("reset0");

      // full upward travel from 0
      hold(1'b1, 1'b0, 4);
      settle();
      check_val("first_step_pos", int'(position), 1);
      hold(1'b1, 1'b0, 3996);
      settle();
      check_val("full_travel_pos", int'(position), 1000);
      check_val("full_travel_up_limit", int'(up_limit), 1);
      hold(1'b1, 1'b0, 20);
      settle();
      check_val("top_saturate_pos", int'(position), 1000);
      check_val("top_saturate_moving", int'(moving), 0);

      // short downward burst, partial third step discarded
      hold(1'b0, 1'b0, 2);
      hold(1'b0, 1'b1, 10);
      hold(1'b0, 1'b0, 5);
      settle();
      check_val("dn_burst_pos", int'(position), 998);

      // move to mid travel, then reverse mid-step
      hold(1'b0, 1'b1, 1992);
      hold(1'b0, 1'b0, 2);
      settle();
      check_val("mid_pos", int'(position), 500);
      hold(1'b1, 1'b0, 6);
      settle();
      check_val("rev_up_pos", int'(position), 501);
      hold(1'b0, 1'b1, 6);
      settle();
      check_val("rev_dn_pos", int'(position), 500);
      hold(1'b0, 1'b0, 2);

      // conflicting drive latches fault and freezes position
      cyc(1'b1, 1'b1);
      hold(1'b1, 1'b0, 20);
      settle();
      check_val("fault_set", int'(fault), 1);
      check_val("fault_frozen_pos", int'(position), 500);
      do_reset("reset_after_fault");

      // randomized drive bursts with periodic reset
      for (int blk = 0; blk < 120; blk++) begin
         mode = $urandom_range(0, 15);
         len  = $urandom_range(1, 40);
         if (blk % 30 == 29) begin
            do_reset("reset_rand");
         end else if (mode == 0) begin
            cyc(1'b1, 1'b1);
         end else if (mode <= 7) begin
            hold(1'b1, 1'b0, len);
         end else if (mode <= 11) begin
            hold(1'b0, 1'b1, len);
         end else begin
            hold(1'b0, 1'b0, len);
         end
      end
      hold(1'b0, 1'b0, 2);
      settle();
      check_val("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
